// File: rtl/mem_access_ctrl.sv
// Front-end for the eight-byte memory array: clears every location after reset,
// then runs each accepted command through setup/strobe/hold phases and returns read data.
module mem_access_ctrl #(
  parameter int         SETUP_CYCLES  = 1,
  parameter int         STROBE_CYCLES = 1,
  parameter logic [7:0] INIT_VALUE    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [2:0] rsp_addr,
  output logic       init_done,
  output logic [7:0] mem_i,
  output logic [2:0] mem_adr,
  output logic       mem_rw,
  output logic       mem_i_valid,
  input  logic [7:0] mem_o
);
  localparam int MAX_CYCLES = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);

  typedef enum logic [3:0] {
    INIT_SETUP, INIT_STROBE, INIT_HOLD, IDLE, SETUP, STROBE, HOLD, CAPTURE, RESP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      init_adr_q, init_adr_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_rdata_q, rsp_rdata_d;
  logic [2:0]      rsp_addr_q, rsp_addr_d;
  logic            init_done_q, init_done_d;
  logic [7:0]      mem_i_q, mem_i_d;
  logic [2:0]      mem_adr_q, mem_adr_d;
  logic            mem_rw_q, mem_rw_d;
  logic            mem_i_valid_q, mem_i_valid_d;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the source holds valid and its payload stable until that edge.
  // Every output is a flop, so each *_d value is what the pin shows in the next state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    init_adr_d    = init_adr_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_addr_d    = rsp_addr_q;
    init_done_d   = init_done_q;
    mem_i_d       = mem_i_q;
    mem_adr_d     = mem_adr_q;
    mem_rw_d      = mem_rw_q;
    mem_i_valid_d = mem_i_valid_q;
    unique case (state_q)
      INIT_SETUP: begin
        mem_adr_d = init_adr_q;
        mem_i_d   = INIT_VALUE;
        mem_rw_d  = 1'b1;
        if (cnt_q == SETUP_LAST) begin
          state_d       = INIT_STROBE;
          mem_i_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      INIT_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d       = INIT_HOLD;
          mem_i_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      INIT_HOLD: begin
        // Stops at the last address instead of wrapping into a second pass.
        if (init_adr_q == 3'd7) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
          cmd_ready_d = 1'b1;
        end else begin
          state_d    = INIT_SETUP;
          init_adr_d = init_adr_q + 3'd1;
          mem_adr_d  = init_adr_q + 3'd1;
        end
      end
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          mem_rw_d    = cmd_rw;
          mem_adr_d   = cmd_addr;
          mem_i_d     = cmd_rw ? cmd_wdata : 8'h00;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d       = STROBE;
          mem_i_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          mem_i_valid_d = 1'b0;
          if (mem_rw_q) begin
            state_d = HOLD;
          end else begin
            state_d     = CAPTURE;
            rsp_rdata_d = mem_o;
            rsp_addr_d  = mem_adr_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
      CAPTURE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = INIT_SETUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT_SETUP;
      cnt_q         <= '0;
      init_adr_q    <= 3'd0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 8'h00;
      rsp_addr_q    <= 3'd0;
      init_done_q   <= 1'b0;
      mem_i_q       <= 8'h00;
      mem_adr_q     <= 3'd0;
      mem_rw_q      <= 1'b0;
      mem_i_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      init_adr_q    <= init_adr_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_addr_q    <= rsp_addr_d;
      init_done_q   <= init_done_d;
      mem_i_q       <= mem_i_d;
      mem_adr_q     <= mem_adr_d;
      mem_rw_q      <= mem_rw_d;
      mem_i_valid_q <= mem_i_valid_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_addr    = rsp_addr_q;
  assign init_done   = init_done_q;
  assign mem_i       = mem_i_q;
  assign mem_adr     = mem_adr_q;
  assign mem_rw      = mem_rw_q;
  assign mem_i_valid = mem_i_valid_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a default instance plus a SETUP=3/STROBE=2 instance,
// each wired to a small memory array, checked against a byte-array reference model.
module tb_mem_access_ctrl;
  localparam logic [7:0] INIT_A = 8'h00;
  localparam int         S_A = 1, T_A = 1;
  localparam logic [7:0] INIT_B = 8'h5A;
  localparam int         S_B = 3, T_B = 2;

  logic clk = 1'b0, rst = 1'b1, b_rst = 1'b1, scramble = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid, cmd_ready, cmd_rw, rsp_valid, rsp_ready, init_done, mem_rw, mem_i_valid;
  logic [2:0] cmd_addr, rsp_addr, mem_adr;
  logic [7:0] cmd_wdata, rsp_rdata, mem_i, mem_o;
  logic       b_cmd_valid, b_cmd_ready, b_cmd_rw, b_rsp_valid, b_rsp_ready, b_init_done, b_mem_rw, b_mem_i_valid;
  logic [2:0] b_cmd_addr, b_rsp_addr, b_mem_adr;
  logic [7:0] b_cmd_wdata, b_rsp_rdata, b_mem_i, b_mem_o;

  mem_access_ctrl dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr), .init_done(init_done), .mem_i(mem_i),
    .mem_adr(mem_adr), .mem_rw(mem_rw), .mem_i_valid(mem_i_valid), .mem_o(mem_o));

  mem_access_ctrl #(.SETUP_CYCLES(S_B), .STROBE_CYCLES(T_B), .INIT_VALUE(INIT_B)) dut_b (
    .clk(clk), .rst(b_rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_rw(b_cmd_rw),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_addr(b_rsp_addr), .init_done(b_init_done), .mem_i(b_mem_i),
    .mem_adr(b_mem_adr), .mem_rw(b_mem_rw), .mem_i_valid(b_mem_i_valid), .mem_o(b_mem_o));

  // Memory arrays: write while i_valid&rw at a rising edge, combinational read.
  logic [7:0] ram_a [8];
  logic [7:0] ram_b [8];
  always @(posedge clk) begin
    if (scramble) begin
      foreach (ram_a[i]) ram_a[i] <= 8'($urandom);
      foreach (ram_b[i]) ram_b[i] <= 8'($urandom);
    end else begin
      if (mem_i_valid && mem_rw) ram_a[mem_adr] <= mem_i;
      if (b_mem_i_valid && b_mem_rw) ram_b[b_mem_adr] <= b_mem_i;
    end
  end
  assign mem_o   = ram_a[mem_adr];
  assign b_mem_o = ram_b[b_mem_adr];

  int checks = 0, failures = 0;
  logic [7:0]  exp_mem [8];
  logic [7:0]  b_exp   [8];
  logic [10:0] exp_q[$];
  logic [11:0] strobe_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe-shape monitors: setup length before each strobe, exact strobe width,
  // and pins frozen while the strobe is high.
  int lo_a, hi_a, lo_b, hi_b;
  logic prev_a, prev_b;
  logic [11:0] snap_a, snap_b;
  always @(negedge clk) begin
    if (rst) begin
      lo_a <= 0; hi_a <= 0; prev_a <= 1'b0;
    end else if (mem_i_valid) begin
      if (!prev_a) begin
        check("setup_len_a", 32'(lo_a >= S_A), 1);
        strobe_q.push_back({mem_rw, mem_adr, mem_i});
        snap_a <= {mem_rw, mem_adr, mem_i};
        hi_a   <= 1;
      end else begin
        check("stable_a", 32'({mem_rw, mem_adr, mem_i}), 32'(snap_a));
        hi_a <= hi_a + 1;
      end
      prev_a <= 1'b1;
    end else begin
      if (prev_a) begin
        check("strobe_len_a", hi_a, T_A);
        lo_a <= 1;
      end else begin
        lo_a <= lo_a + 1;
      end
      prev_a <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (b_rst) begin
      lo_b <= 0; hi_b <= 0; prev_b <= 1'b0;
    end else if (b_mem_i_valid) begin
      if (!prev_b) begin
        check("setup_len_b", 32'(lo_b >= S_B), 1);
        snap_b <= {b_mem_rw, b_mem_adr, b_mem_i};
        hi_b   <= 1;
      end else begin
        check("stable_b", 32'({b_mem_rw, b_mem_adr, b_mem_i}), 32'(snap_b));
        hi_b <= hi_b + 1;
      end
      prev_b <= 1'b1;
    end else begin
      if (prev_b) begin
        check("strobe_len_b", hi_b, T_B);
        lo_b <= 1;
      end else begin
        lo_b <= lo_b + 1;
      end
      prev_b <= 1'b0;
    end
  end

  task automatic check_strobe(input logic [11:0] e);
    check("strobe_present", 32'(strobe_q.size()), 1);
    if (strobe_q.size() > 0) check("strobe_fields", 32'(strobe_q.pop_front()), 32'(e));
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("init_cycle", n, 8 * (S_A + T_A + 1) + 1);
    check("init_cmd_ready", 32'(cmd_ready), 1);
    check("init_strobe_count", 32'(strobe_q.size()), 8);
    for (int k = 0; k < 8; k++)
      if (strobe_q.size() > 0) check("init_strobe", 32'(strobe_q.pop_front()), 32'({1'b1, 3'(k), INIT_A}));
  endtask

  task automatic send_cmd(input logic rw, input logic [2:0] a, input logic [7:0] d);
    int n = 0;
    cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (rw) exp_mem[a] = d;
    else exp_q.push_back({a, exp_mem[a]});
  endtask

  task automatic write_tail(input logic [2:0] a, input logic [7:0] d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 50);
    check("wr_busy_cycles", n, S_A + T_A + 2);
    check_strobe({1'b1, a, d});
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    send_cmd(1'b1, a, d);
    write_tail(a, d);
  endtask

  task automatic do_read(input logic [2:0] a, input int delay);
    int n = 0;
    logic [10:0] e;
    rsp_ready = (delay == 0);
    send_cmd(1'b0, a, 8'h00);
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 50);
    check("rd_latency", n, S_A + T_A + 2);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7ff;
    check("rd_addr", 32'(rsp_addr), 32'(e[10:8]));
    check("rd_data", 32'(rsp_rdata), 32'(e[7:0]));
    repeat (delay) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 1);
      check("stall_payload", 32'({rsp_addr, rsp_rdata}), 32'(e));
      check("stall_cmd_ready", 32'(cmd_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rsp_drop", 32'(rsp_valid), 0);
    check_strobe({1'b0, a, 8'h00});
  endtask

  task automatic b_send(input logic rw, input logic [2:0] a, input logic [7:0] d);
    int n = 0;
    b_cmd_rw = rw; b_cmd_addr = a; b_cmd_wdata = d; b_cmd_valid = 1'b1;
    while (!b_cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_accept_ready", 32'(b_cmd_ready), 1);
    @(posedge clk);
    #1 b_cmd_valid = 1'b0;
    if (rw) b_exp[a] = d;
  endtask

  task automatic b_access(input logic rw, input logic [2:0] a, input logic [7:0] d);
    int n = 0;
    logic [7:0] e;
    e = b_exp[a];
    b_send(rw, a, d);
    do begin
      @(negedge clk);
      n++;
    end while (!(rw ? b_cmd_ready : b_rsp_valid) && n < 100);
    check(rw ? "b_wr_busy_cycles" : "b_rd_latency", n, S_B + T_B + 2);
    if (!rw) begin
      check("b_rd_addr", 32'(b_rsp_addr), 32'(a));
      check("b_rd_data", 32'(b_rsp_rdata), 32'(e));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("b_rsp_drop", 32'(b_rsp_valid), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [10:0] e;
    int n;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 3'd0; cmd_wdata = 8'h00; rsp_ready = 1'b1;
    b_cmd_valid = 1'b0; b_cmd_rw = 1'b0; b_cmd_addr = 3'd0; b_cmd_wdata = 8'h00; b_rsp_ready = 1'b1;
    foreach (exp_mem[i]) exp_mem[i] = INIT_A;
    foreach (b_exp[i]) b_exp[i] = INIT_B;

    repeat (3) @(posedge clk);
    #1 scramble = 1'b0;
    @(negedge clk);
    check("reset_outputs_a", 32'({cmd_ready, rsp_valid, rsp_rdata, rsp_addr, init_done,
                                  mem_i, mem_adr, mem_rw, mem_i_valid}), 0);
    check("reset_outputs_b", 32'({b_cmd_ready, b_rsp_valid, b_rsp_rdata, b_rsp_addr, b_init_done,
                                  b_mem_i, b_mem_adr, b_mem_rw, b_mem_i_valid}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_init();

    do_write(3'd0, 8'hFF);
    do_read(3'd0, 0);
    do_write(3'd1, 8'hFC);
    do_read(3'd2, 0);
    do_read(3'd1, 0);

    // Stalled response with the next command already waiting on cmd_valid.
    rsp_ready = 1'b0;
    send_cmd(1'b0, 3'd1, 8'h00);
    cmd_rw = 1'b1; cmd_addr = 3'd3; cmd_wdata = 8'h3C; cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 50);
    check("stall_rd_latency", n, S_A + T_A + 2);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7ff;
    check("stall_rd_payload", 32'({rsp_addr, rsp_rdata}), 32'(e));
    check_strobe({1'b0, 3'd1, 8'h00});
    repeat (10) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 1);
      check("stall_payload", 32'({rsp_addr, rsp_rdata}), 32'(e));
      check("stall_cmd_ready", 32'(cmd_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_release_valid", 32'(rsp_valid), 0);
    check("stall_release_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;
    check("held_cmd_accepted", 32'(cmd_ready), 0);
    cmd_valid = 1'b0;
    exp_mem[3] = 8'h3C;
    write_tail(3'd3, 8'h3C);
    do_read(3'd3, 0);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) do_write(3'($urandom_range(0, 7)), 8'($urandom));
      else do_read(3'($urandom_range(0, 7)), $urandom_range(0, 3));
    end

    // Reset during the strobe of a write to address 5.
    cmd_rw = 1'b1; cmd_addr = 3'd5; cmd_wdata = 8'hA5; cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_i_valid && n < 20);
    check("abort_reached_strobe", 32'(mem_i_valid), 1);
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_strobe_low", 32'(mem_i_valid), 0);
    check("abort_init_done", 32'(init_done), 0);
    check("abort_cmd_ready", 32'(cmd_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    foreach (exp_mem[i]) exp_mem[i] = INIT_A;
    exp_q.delete();
    strobe_q.delete();
    wait_init();
    do_read(3'd5, 0);

    // Stretched-phase instance.
    @(posedge clk);
    #1 b_rst = 1'b0;
    n = 0;
    while (!b_init_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_init_cycle", n, 8 * (S_B + T_B + 1) + 1);
    b_access(1'b0, 3'd2, 8'h00);
    b_access(1'b1, 3'd6, 8'($urandom));
    b_access(1'b0, 3'd6, 8'h00);
    for (int i = 0; i < 8; i++)
      b_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Synchronous front-end that sits directly upstream of the eight-byte memory array.
- Accepts read/write commands over a valid/ready handshake and sequences the memory's address, data, rw and i_valid pins with fixed setup/strobe/hold phases.
- Captures read data and returns it over a valid/ready response channel.
- After every reset, clears all eight locations before accepting commands.

Parameters:
- SETUP_CYCLES, 1: cycles address/data/rw are stable with mem_i_valid low before the strobe (>=1).
- STROBE_CYCLES, 1: cycles mem_i_valid is held high (>=1).
- INIT_VALUE, 8'h00: byte written to every address during post-reset init.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_rw  in  1  1 = write, 0 = read (same polarity as memory rw)
- cmd_addr  in  3  target address
- cmd_wdata  in  8  write data; ignored for reads
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  8  captured read byte
- rsp_addr  out  3  address the response belongs to
- init_done  out  1  high once post-reset clear has completed
- mem_i  out  8  to memory data inputs; bit k drives ik
- mem_adr  out  3  to memory address; bit k drives adrk
- mem_rw  out  1  to memory rw
- mem_i_valid  out  1  to memory i_valid strobe
- mem_o  in  8  from memory outputs; bit k from ok

Behaviour:
- Reset values (all outputs registered): cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_addr=0, init_done=0, mem_i=0, mem_adr=0, mem_rw=0, mem_i_valid=0.
- FSM states: INIT_SETUP, INIT_STROBE, INIT_HOLD, IDLE, SETUP, STROBE, HOLD, CAPTURE, RESP. Reset state is INIT_SETUP with init address 0.
- INIT:
  - For each address 0..7: mem_adr=addr, mem_i=INIT_VALUE, mem_rw=1.
  - mem_i_valid=0 for SETUP_CYCLES, then 1 for STROBE_CYCLES, then 0 for 1 HOLD cycle.
  - After the hold of address 7: init_done=1 and go to IDLE.
  - With defaults, init takes 24 cycles; init_done is high in cycle 25 after reset deasserts.
- IDLE: cmd_ready=1. Accept when cmd_valid&cmd_ready at a rising edge. Latch rw/addr/wdata into mem_rw/mem_adr/mem_i, deassert cmd_ready, go to SETUP.
- cmd_ready is 0 in every state except IDLE. Commands are never dropped: they are held by the source until accepted.
- SETUP: mem_i_valid=0 for SETUP_CYCLES. STROBE: mem_i_valid=1 for STROBE_CYCLES.
- mem_adr, mem_i and mem_rw are constant from the accept edge through the end of HOLD/CAPTURE; they never change while mem_i_valid=1.
- Write path: STROBE -> HOLD (mem_i_valid=0, 1 cycle) -> IDLE. No response is generated. Defaults give cmd_ready low for 3 cycles after the accept edge.
- Read path: mem_i=0 and mem_rw=0. During the last STROBE cycle, mem_o is sampled into rsp_rdata and mem_adr into rsp_addr. Then CAPTURE (mem_i_valid=0, 1 cycle) -> RESP.
- RESP: rsp_valid=1 with rsp_rdata/rsp_addr stable until rsp_valid&rsp_ready. Then rsp_valid=0 and go to IDLE.
  - With defaults and rsp_ready=1, rsp_valid rises 3 cycles after the accept edge.
  - If rsp_ready is held low, rsp_valid stays high indefinitely and no new command is accepted.
- Back-to-back: a command presented while cmd_ready=0 is accepted on the first IDLE cycle; there is no idle bubble beyond that single cycle.
- Internal phase counters are wide enough for max(SETUP_CYCLES, STROBE_CYCLES). The init address counter stops at 7 and does not wrap into a second pass.
- Reset mid-operation aborts immediately: all outputs take reset values on the next edge, any pending response is discarded, and INIT restarts from address 0.
- cmd_* inputs during INIT are ignored because cmd_ready=0.

Test Plan:
- Reset release, defaults -> mem_i_valid pulses exactly 8 times at mem_adr 0..7 with mem_rw=1, mem_i=8'h00; init_done rises in cycle 25; cmd_ready rises with it.
- Write addr 0 data 8'hFF, then read addr 0 -> mem_rw=1 with one strobe; then rsp_valid with rsp_rdata=8'hFF, rsp_addr=0, rising 3 cycles after the read accept.
- Write addr 1 = 8'hFC, read addr 2 (untouched since init) -> rsp_rdata=8'h00, rsp_addr=2; then read addr 1 -> rsp_rdata=8'hFC.
- Read addr 1 with rsp_ready=0 for 10 cycles, next command held on cmd_valid -> rsp_valid and rsp_rdata stable throughout, cmd_ready=0; after rsp_ready=1, the next command is accepted on the following IDLE cycle.
- SETUP_CYCLES=3, STROBE_CYCLES=2 -> mem_i_valid low 3 cycles then high exactly 2 per access; address/data never change while mem_i_valid=1 (assertion).
- Assert rst during STROBE of a write to addr 5 -> mem_i_valid=0 next edge, init_done=0, full init re-runs, and a subsequent read of addr 5 returns INIT_VALUE.
